// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Refills from a slower word memory over a req/ready handshake; Stall freezes the pipeline.
module dcache_wt #(
    parameter int INDEX_BITS = 4,
    parameter int WORDS      = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemReady,
    output logic [31:0] HitCount,
    output logic [31:0] MissCount
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 32 - INDEX_BITS - 4;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              refilled_q, refilled_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;
    logic [LINES-1:0]  valid_q, valid_d;

    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES][WORDS];

    logic [TAG_W-1:0]      tag_a;
    logic [INDEX_BITS-1:0] idx_a;
    logic [1:0]            word_a;
    logic                  hit;
    logic                  tag_we;
    logic                  data_we;
    logic [1:0]            data_word;
    logic [31:0]           data_wdata;
    logic                  unused_addr_lsb;

    assign tag_a           = Addr[31:INDEX_BITS+4];
    assign idx_a           = Addr[INDEX_BITS+3:4];
    assign word_a          = Addr[3:2];
    assign hit             = valid_q[idx_a] && (tag_q[idx_a] == tag_a);
    assign unused_addr_lsb = ^Addr[1:0];

    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        refilled_d = refilled_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        valid_d    = valid_q;
        tag_we     = 1'b0;
        data_we    = 1'b0;
        data_word  = 2'd0;
        data_wdata = 32'd0;
        ReadData   = 32'd0;
        Stall      = 1'b0;
        MemReq     = 1'b0;
        MemWE      = 1'b0;
        MemAddr    = 32'd0;
        MemWData   = 32'd0;

        case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    Stall   = 1'b1;
                    state_d = WRITE;
                end else if (MemRead) begin
                    if (hit) begin
                        ReadData = data_q[idx_a][word_a];
                        // The hit right after a refill is the retried miss, not a new hit.
                        if (refilled_q) begin
                            refilled_d = 1'b0;
                        end else begin
                            hit_cnt_d = hit_cnt_q + 32'd1;
                        end
                    end else begin
                        Stall      = 1'b1;
                        miss_cnt_d = miss_cnt_q + 32'd1;
                        cnt_d      = 2'd0;
                        state_d    = REFILL;
                    end
                end
            end
            REFILL: begin
                Stall   = 1'b1;
                MemReq  = 1'b1;
                MemAddr = {tag_a, idx_a, cnt_q, 2'b00};
                if (MemReady) begin
                    data_we    = 1'b1;
                    data_word  = cnt_q;
                    data_wdata = MemRData;
                    cnt_d      = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        valid_d[idx_a] = 1'b1;
                        tag_we         = 1'b1;
                        refilled_d     = 1'b1;
                        state_d        = IDLE;
                    end
                end
            end
            WRITE: begin
                MemReq   = 1'b1;
                MemWE    = 1'b1;
                MemAddr  = {Addr[31:2], 2'b00};
                MemWData = WriteData;
                Stall    = ~MemReady;
                if (MemReady) begin
                    if (hit) begin
                        data_we    = 1'b1;
                        data_word  = word_a;
                        data_wdata = WriteData;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Hold everything quiet while reset is asserted so an aborted transaction leaves no trace.
        if (!Reset) begin
            tag_we   = 1'b0;
            data_we  = 1'b0;
            ReadData = 32'd0;
            Stall    = 1'b0;
            MemReq   = 1'b0;
            MemWE    = 1'b0;
            MemAddr  = 32'd0;
            MemWData = 32'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            refilled_q <= 1'b0;
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            refilled_q <= refilled_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge CLK) begin
        if (tag_we) begin
            tag_q[idx_a] <= tag_a;
        end
        if (data_we) begin
            data_q[idx_a][data_word] <= data_wdata;
        end
    end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipeline's memory stage and a slower backing word memory.
- Answers the pipeline's data requests (ALUOutM/WriteDataM/ReadDataM side) and raises Stall on a miss or write so the pipeline freezes.
- Refills 4-word lines from backing memory over a req/ready handshake.

Parameters:
INDEX_BITS, 4, line index width; 2^INDEX_BITS lines. Tag = 32-INDEX_BITS-4 bits.
WORDS, 4, words per line. Fixed at 4; the word offset is Addr[3:2].

Ports:
CLK  in  1  clock, all state on rising edge
Reset  in  1  synchronous, active-low reset
Addr  in  32  CPU byte address; Addr[1:0] ignored
WriteData  in  32  CPU store data
MemRead  in  1  CPU load request
MemWrite  in  1  CPU store request; wins if MemRead is also high
ReadData  out  32  load data, valid when MemRead=1 and Stall=0
Stall  out  1  combinational; CPU holds Addr/WriteData/MemRead/MemWrite stable while high
MemReq  out  1  backing-memory request
MemWE  out  1  1 = write, 0 = read
MemAddr  out  32  word-aligned backing address
MemWData  out  32  backing write data
MemRData  in  32  backing read data, valid with MemReady
MemReady  in  1  one-cycle completion pulse; ignored when MemReq=0
HitCount  out  32  completed load hits
MissCount  out  32  load misses

Behaviour:
- Address split: tag = Addr[31:INDEX_BITS+4], index = Addr[INDEX_BITS+3:4], word = Addr[3:2].
- Hit condition: valid[index] and the stored tag matches.
- Storage: valid bits, tags and data words are registers; tag/data have no reset value.
- States: IDLE, REFILL, WRITE.
- Reset (Reset=0 at an edge):
  - State goes to IDLE; all valid bits are cleared.
  - Refill counter = 0, refilled flag = 0, HitCount = 0, MissCount = 0.
  - Outputs are 0 the following cycle: MemReq, MemWE, MemAddr, MemWData, ReadData, Stall.
  - Reset mid-REFILL or mid-WRITE aborts the transaction immediately; no partial line is marked valid.
- IDLE, no request: Stall=0, MemReq=0, ReadData=0.
- IDLE, load hit:
  - Stall=0; ReadData = line word, combinational, same cycle.
  - HitCount += 1, unless the refilled flag is set. The flag marks the retry that follows a refill; it is cleared on this edge.
- IDLE, load miss:
  - Stall=1; MissCount += 1; counter = 0; next state REFILL.
- IDLE, store (hit or miss):
  - Stall=1; next state WRITE.
- REFILL:
  - Stall=1, MemReq=1, MemWE=0, MemAddr = {tag, index, counter, 2'b00}.
  - On each MemReady: data[index][counter] <= MemRData; counter += 1.
  - On MemReady with counter=3: valid[index] <= 1, tag stored, refilled <= 1, next state IDLE.
  - The retried load then hits with zero extra stall.
  - Miss penalty = sum of 4 backing latencies + 1 cycle.
- WRITE:
  - MemReq=1, MemWE=1, MemAddr = {Addr[31:2], 2'b00}, MemWData = WriteData.
  - Stall = ~MemReady.
  - On MemReady: if hit, the cached word is updated with WriteData; next state IDLE. On miss there is no allocation.
  - The pipeline advances on the same edge.
- Back-to-back requests: a new request in the cycle after WRITE/REFILL completes is evaluated normally in IDLE.
- Counters wrap at 2^32.
- Must run with any MemReady latency ≥ 1 cycle. MemReady asserted in the same cycle MemReq first rises is legal.

Test Plan:
1. Cold miss: after reset, with mem[a] = a+0x1000 and ready 2 cycles after each request, load 0x40 → MemAddr sequence 0x40, 0x44, 0x48, 0x4C; Stall drops one cycle after the 4th ready; ReadData = 0x1040; HitCount = 0, MissCount = 1.
2. Line hit: following test 1, load 0x48 → Stall=0 the same cycle, ReadData = 0x1048, MemReq stays 0, HitCount = 1.
3. Conflict: load 0x440 (index 4, new tag) → refill from 0x440..0x44C, ReadData = 0x1440; a subsequent load of 0x40 misses again; MissCount = 3.
4. Store hit then load: store 0xDEADBEEF to 0x44 with line 0x40 resident → one MemWE=1 request at 0x44; Stall low in the ready cycle; a subsequent load of 0x44 returns 0xDEADBEEF with no memory traffic.
5. Store miss / no-allocate: store 0x12345678 to 0x80 → one write, no refill; a subsequent load of 0x80 misses, MissCount increments, and the data comes from memory.
6. Reset mid-refill: drive Reset=0 after the 2nd refill ready → next cycle MemReq=0, Stall=0, counters = 0; after release, load 0x40 misses and fully refills.
